// File: rtl/gpio_ext.sv
// gpio_ext: NUM_PINS-pin GPIO bus slave with synchronised inputs, atomic set/clear/toggle and per-pin interrupts.
// Optional per-pin input debounce (DEB_CNT register at 0x2C) is built when GPIO_DEBOUNCE_EN is defined.
package gpio_ext_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic        w_en;
        logic        req;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;
endpackage

module gpio_ext
    import gpio_ext_pkg::*;
#(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gpio_sel_i,
    input  type_dbus2peri_s      dbus2gpio_i,
    output type_peri2dbus_s      gpio2dbus_o,
    output logic                 gpio_irq_o,
    inout  wire  [NUM_PINS-1:0]  gpio_io
);

    localparam logic [3:0] ADDR_DATA_OUT = 4'h0;
    localparam logic [3:0] ADDR_DIR      = 4'h1;
    localparam logic [3:0] ADDR_DATA_IN  = 4'h2;
    localparam logic [3:0] ADDR_SET      = 4'h3;
    localparam logic [3:0] ADDR_CLR      = 4'h4;
    localparam logic [3:0] ADDR_TGL      = 4'h5;
    localparam logic [3:0] ADDR_IRQ_EN   = 4'h6;
    localparam logic [3:0] ADDR_IRQ_TYPE = 4'h7;
    localparam logic [3:0] ADDR_IRQ_POL  = 4'h8;
    localparam logic [3:0] ADDR_IRQ_BOTH = 4'h9;
    localparam logic [3:0] ADDR_IRQ_PEND = 4'hA;
    localparam logic [3:0] ADDR_DEB_CNT  = 4'hB;

    function automatic logic [31:0] zext(input logic [NUM_PINS-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[NUM_PINS-1:0] = v;
        return r;
    endfunction

    logic                acc_s, wr_s, rd_s;
    logic [3:0]          idx_s;
    logic [NUM_PINS-1:0] wdat_s;
    logic                unused_s;

    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PINS-1:0] irq_type_q, irq_type_d;
    logic [NUM_PINS-1:0] irq_pol_q, irq_pol_d;
    logic [NUM_PINS-1:0] irq_both_q, irq_both_d;
    logic [NUM_PINS-1:0] pend_q, pend_d;
    logic [NUM_PINS-1:0] w1c_s;
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_in_s, filt_s, in_q;
    logic [NUM_PINS-1:0] rise_s, fall_s, edge_ev_s, level_ev_s, ev_s;
    logic [31:0]         rdata_q, rdata_d;
    logic                ack_q, irq_q;

    assign acc_s    = gpio_sel_i & dbus2gpio_i.req;
    assign wr_s     = acc_s & dbus2gpio_i.w_en;
    assign rd_s     = acc_s & ~dbus2gpio_i.w_en;
    assign idx_s    = dbus2gpio_i.addr[5:2];
    assign wdat_s   = dbus2gpio_i.w_data[NUM_PINS-1:0];
    assign unused_s = ^{dbus2gpio_i.addr[31:6], dbus2gpio_i.addr[1:0], dbus2gpio_i.w_data};

    // Pad input synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_io;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_in_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0]    deb_q [NUM_PINS];
    logic [NUM_PINS-1:0] filt_q;

    // Per-pin debounce: follow sync_in only after it has differed for DEB_CNT+1 cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_PINS; i++) deb_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (sync_in_s[i] != filt_q[i]) begin
                    if (deb_q[i] == deb_cnt_q) begin
                        filt_q[i] <= sync_in_s[i];
                        deb_q[i]  <= '0;
                    end else begin
                        deb_q[i]  <= deb_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_q[i] <= '0;
                end
            end
        end
    end

    assign filt_s = filt_q;
`else
    assign filt_s = sync_in_s;
`endif

    assign rise_s     = filt_s & ~in_q;
    assign fall_s     = ~filt_s & in_q;
    assign edge_ev_s  = (irq_both_q & (rise_s | fall_s)) |
                        (~irq_both_q & ((irq_pol_q & rise_s) | (~irq_pol_q & fall_s)));
    assign level_ev_s = ~(filt_s ^ irq_pol_q);
    assign ev_s       = (irq_type_q & edge_ev_s) | (~irq_type_q & level_ev_s);

    // Register write decode; a new event overrides a same-cycle W1C.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        irq_type_d = irq_type_q;
        irq_pol_d  = irq_pol_q;
        irq_both_d = irq_both_q;
        w1c_s      = '0;
`ifdef GPIO_DEBOUNCE_EN
        deb_cnt_d  = deb_cnt_q;
`endif
        if (wr_s) begin
            case (idx_s)
                ADDR_DATA_OUT: data_out_d = wdat_s;
                ADDR_DIR:      dir_d      = wdat_s;
                ADDR_SET:      data_out_d = data_out_q | wdat_s;
                ADDR_CLR:      data_out_d = data_out_q & ~wdat_s;
                ADDR_TGL:      data_out_d = data_out_q ^ wdat_s;
                ADDR_IRQ_EN:   irq_en_d   = wdat_s;
                ADDR_IRQ_TYPE: irq_type_d = wdat_s;
                ADDR_IRQ_POL:  irq_pol_d  = wdat_s;
                ADDR_IRQ_BOTH: irq_both_d = wdat_s;
                ADDR_IRQ_PEND: w1c_s      = wdat_s;
`ifdef GPIO_DEBOUNCE_EN
                ADDR_DEB_CNT:  deb_cnt_d  = dbus2gpio_i.w_data[DEB_W-1:0];
`endif
                default:       w1c_s      = '0;
            endcase
        end else begin
            w1c_s = '0;
        end
        pend_d = (pend_q & ~w1c_s) | ev_s;
    end

    // Read data mux; zero outside read accesses.
    always_comb begin
        rdata_d = 32'd0;
        if (rd_s) begin
            case (idx_s)
                ADDR_DATA_OUT: rdata_d = zext(data_out_q);
                ADDR_DIR:      rdata_d = zext(dir_q);
                ADDR_DATA_IN:  rdata_d = zext(filt_s);
                ADDR_IRQ_EN:   rdata_d = zext(irq_en_q);
                ADDR_IRQ_TYPE: rdata_d = zext(irq_type_q);
                ADDR_IRQ_POL:  rdata_d = zext(irq_pol_q);
                ADDR_IRQ_BOTH: rdata_d = zext(irq_both_q);
                ADDR_IRQ_PEND: rdata_d = zext(pend_q);
`ifdef GPIO_DEBOUNCE_EN
                ADDR_DEB_CNT:  rdata_d = 32'(deb_cnt_q);
`endif
                default:       rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Control/status registers, bus response and combined interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_type_q <= '0;
            irq_pol_q  <= '0;
            irq_both_q <= '0;
            pend_q     <= '0;
            in_q       <= '0;
            rdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
            deb_cnt_q  <= '0;
`endif
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_type_q <= irq_type_d;
            irq_pol_q  <= irq_pol_d;
            irq_both_q <= irq_both_d;
            pend_q     <= pend_d;
            in_q       <= filt_s;
            rdata_q    <= rdata_d;
            ack_q      <= acc_s;
            irq_q      <= |(pend_q & irq_en_q);
`ifdef GPIO_DEBOUNCE_EN
            deb_cnt_q  <= deb_cnt_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pad
        assign gpio_io[g] = dir_q[g] ? data_out_q[g] : 1'bz;
    end

    assign gpio2dbus_o = {rdata_q, ack_q};
    assign gpio_irq_o  = irq_q;

endmodule
